// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with split-transaction parking, resume priority and a
// split watchdog. All outputs are registered; reset is synchronous, active-low.
module bus_arbiter #(
  parameter int PRIORITY_MODE = 0,
  parameter int SPLIT_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m1_request,
  input  logic       m2_request,
  input  logic       split_req,
  input  logic       split_resume,
  output logic       m1_grant,
  output logic       m2_grant,
  output logic [1:0] bus_owner,
  output logic       m1_split,
  output logic       m2_split,
  output logic       split_timeout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_M1 = 2'd1,
    OWN_M2 = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(SPLIT_TIMEOUT - 1);
  localparam bit         WATCHDOG_ON  = (SPLIT_TIMEOUT != 0);

  state_t     state, state_nxt;
  logic [7:0] wd_cnt, wd_cnt_nxt;
  logic       last_m1, last_m1_nxt;
  logic       rp_m1, rp_m1_nxt;
  logic       rp_m2, rp_m2_nxt;
  logic       m1_split_nxt, m2_split_nxt, timeout_nxt;

  logic elig1, elig2, any_split, resume_hit, slot_free, split_hit, pick_m1;

  assign elig1      = m1_request && !m1_split;
  assign elig2      = m2_request && !m2_split;
  assign any_split  = m1_split || m2_split;
  assign resume_hit = split_resume && any_split;
  // A resume in the same cycle frees the single split slot for a new split_req.
  assign slot_free  = !any_split || resume_hit;
  assign split_hit  = split_req && slot_free && (state != IDLE);
  // last_m1 == 0 means M2 owned last, so M1 wins the first round-robin contention.
  assign pick_m1    = rp_m1 || (!rp_m2 && ((PRIORITY_MODE == 0) || !last_m1));

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_nxt    = state;
    wd_cnt_nxt   = wd_cnt;
    last_m1_nxt  = last_m1;
    rp_m1_nxt    = rp_m1;
    rp_m2_nxt    = rp_m2;
    m1_split_nxt = m1_split;
    m2_split_nxt = m2_split;
    timeout_nxt  = 1'b0;

    unique case (state)
      IDLE: begin
        if (!m1_request) rp_m1_nxt = 1'b0;
        if (!m2_request) rp_m2_nxt = 1'b0;
        if (elig1 && elig2) state_nxt = pick_m1 ? OWN_M1 : OWN_M2;
        else if (elig1)     state_nxt = OWN_M1;
        else if (elig2)     state_nxt = OWN_M2;
      end
      OWN_M1: begin
        if (m1_request && !split_hit) state_nxt = OWN_M1;
        else if (elig2)               state_nxt = OWN_M2;
        else                          state_nxt = IDLE;
      end
      OWN_M2: begin
        if (m2_request && !split_hit) state_nxt = OWN_M2;
        else if (elig1)               state_nxt = OWN_M1;
        else                          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (state_nxt == OWN_M1) begin
      last_m1_nxt = 1'b1;
      rp_m1_nxt   = 1'b0;
    end else if (state_nxt == OWN_M2) begin
      last_m1_nxt = 1'b0;
      rp_m2_nxt   = 1'b0;
    end

    if (resume_hit) begin
      if (m1_split) begin
        m1_split_nxt = 1'b0;
        rp_m1_nxt    = 1'b1;
      end else begin
        m2_split_nxt = 1'b0;
        rp_m2_nxt    = 1'b1;
      end
    end else if (any_split) begin
      if (WATCHDOG_ON && (wd_cnt == TIMEOUT_LAST)) begin
        m1_split_nxt = 1'b0;
        m2_split_nxt = 1'b0;
        timeout_nxt  = 1'b1;
      end else begin
        wd_cnt_nxt = wd_cnt + 8'd1;
      end
    end

    if (split_hit) begin
      wd_cnt_nxt = 8'd0;
      if (state == OWN_M1) m1_split_nxt = 1'b1;
      else                 m2_split_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!reset) begin
      state         <= IDLE;
      wd_cnt        <= 8'd0;
      last_m1       <= 1'b0;
      rp_m1         <= 1'b0;
      rp_m2         <= 1'b0;
      m1_split      <= 1'b0;
      m2_split      <= 1'b0;
      split_timeout <= 1'b0;
      m1_grant      <= 1'b0;
      m2_grant      <= 1'b0;
      bus_owner     <= 2'd0;
    end else begin
      state         <= state_nxt;
      wd_cnt        <= wd_cnt_nxt;
      last_m1       <= last_m1_nxt;
      rp_m1         <= rp_m1_nxt;
      rp_m2         <= rp_m2_nxt;
      m1_split      <= m1_split_nxt;
      m2_split      <= m2_split_nxt;
      split_timeout <= timeout_nxt;
      m1_grant      <= (state_nxt == OWN_M1);
      m2_grant      <= (state_nxt == OWN_M2);
      bus_owner     <= state_nxt;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench: two arbiters (fixed priority and round-robin) share stimulus;
// expected outputs are queued per cycle and checked by a separate monitor.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic reset, m1_request, m2_request, split_req, split_resume;

  logic       a_g1, a_g2, a_s1, a_s2, a_to;
  logic [1:0] a_own;
  logic       b_g1, b_g2, b_s1, b_s2, b_to;
  logic [1:0] b_own;

  typedef struct packed {
    logic [4:0] ea;
    logic [4:0] eb;
    int         idx;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   step_no  = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.PRIORITY_MODE(0), .SPLIT_TIMEOUT(8)) dut_a (
    .clk(clk), .reset(reset), .m1_request(m1_request), .m2_request(m2_request),
    .split_req(split_req), .split_resume(split_resume),
    .m1_grant(a_g1), .m2_grant(a_g2), .bus_owner(a_own),
    .m1_split(a_s1), .m2_split(a_s2), .split_timeout(a_to)
  );

  bus_arbiter #(.PRIORITY_MODE(1), .SPLIT_TIMEOUT(8)) dut_b (
    .clk(clk), .reset(reset), .m1_request(m1_request), .m2_request(m2_request),
    .split_req(split_req), .split_resume(split_resume),
    .m1_grant(b_g1), .m2_grant(b_g2), .bus_owner(b_own),
    .m1_split(b_s1), .m2_split(b_s2), .split_timeout(b_to)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Packs {owner, m1_split, m2_split, split_timeout}.
  function automatic logic [4:0] e(input int owner, input bit s1, input bit s2, input bit to);
    return {2'(owner), s1, s2, to};
  endfunction

  // Expected full output vector {m1_grant, m2_grant, bus_owner, m1_split, m2_split, split_timeout}.
  function automatic logic [6:0] full(input logic [4:0] v);
    return {v[4:3] == 2'd1, v[4:3] == 2'd2, v};
  endfunction

  task automatic cyc(input bit rst_n, input bit r1, input bit r2, input bit sq, input bit sr,
                     input logic [4:0] ea, input logic [4:0] eb);
    exp_t x;
    @(negedge clk);
    reset        = rst_n;
    m1_request   = r1;
    m2_request   = r2;
    split_req    = sq;
    split_resume = sr;
    x.ea  = ea;
    x.eb  = eb;
    x.idx = step_no;
    step_no++;
    q.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        check($sformatf("fixed_step%0d", x.idx),
              32'({a_g1, a_g2, a_own, a_s1, a_s2, a_to}), 32'(full(x.ea)));
        check($sformatf("rr_step%0d", x.idx),
              32'({b_g1, b_g2, b_own, b_s1, b_s2, b_to}), 32'(full(x.eb)));
        check($sformatf("fixed_excl_step%0d", x.idx), 32'(a_g1 & a_g2), 32'(0));
      end
    end
  end

  initial begin : stimulus
    reset = 1'b0; m1_request = 1'b0; m2_request = 1'b0;
    split_req = 1'b0; split_resume = 1'b0;

    // Reset state
    cyc(0, 0, 0, 0, 0, e(0,0,0,0), e(0,0,0,0));
    cyc(0, 0, 0, 0, 0, e(0,0,0,0), e(0,0,0,0));

    // Single request, 16-beat burst
    cyc(1, 0, 0, 0, 0, e(0,0,0,0), e(0,0,0,0));
    cyc(1, 1, 0, 0, 0, e(1,0,0,0), e(1,0,0,0));
    for (int i = 0; i < 15; i++) cyc(1, 1, 0, 0, 0, e(1,0,0,0), e(1,0,0,0));
    cyc(1, 0, 0, 0, 0, e(0,0,0,0), e(0,0,0,0));
    cyc(1, 0, 0, 0, 0, e(0,0,0,0), e(0,0,0,0));

    // Contention: fixed picks M1, round-robin (last M1) picks M2
    for (int i = 0; i < 4; i++) cyc(1, 1, 1, 0, 0, e(1,0,0,0), e(2,0,0,0));
    cyc(1, 0, 1, 0, 0, e(2,0,0,0), e(2,0,0,0));
    cyc(1, 0, 0, 0, 0, e(0,0,0,0), e(0,0,0,0));
    cyc(1, 1, 1, 0, 0, e(1,0,0,0), e(1,0,0,0));
    cyc(1, 0, 1, 0, 0, e(2,0,0,0), e(2,0,0,0));
    cyc(1, 0, 0, 0, 0, e(0,0,0,0), e(0,0,0,0));

    // Split M1, resume while M2 owns, M2 keeps bus, then M1 next
    cyc(1, 1, 0, 0, 0, e(1,0,0,0), e(1,0,0,0));
    cyc(1, 1, 1, 1, 0, e(2,1,0,0), e(2,1,0,0));
    cyc(1, 1, 1, 0, 0, e(2,1,0,0), e(2,1,0,0));
    cyc(1, 1, 1, 0, 1, e(2,0,0,0), e(2,0,0,0));
    cyc(1, 1, 1, 0, 0, e(2,0,0,0), e(2,0,0,0));
    cyc(1, 1, 0, 0, 0, e(1,0,0,0), e(1,0,0,0));
    cyc(1, 0, 0, 0, 0, e(0,0,0,0), e(0,0,0,0));

    // Resume priority beats round-robin in IDLE (last owner M1)
    cyc(1, 1, 0, 0, 0, e(1,0,0,0), e(1,0,0,0));
    cyc(1, 1, 0, 1, 0, e(0,1,0,0), e(0,1,0,0));
    cyc(1, 1, 0, 0, 0, e(0,1,0,0), e(0,1,0,0));
    cyc(1, 1, 0, 0, 1, e(0,0,0,0), e(0,0,0,0));
    cyc(1, 1, 1, 0, 0, e(1,0,0,0), e(1,0,0,0));
    cyc(1, 0, 1, 0, 0, e(2,0,0,0), e(2,0,0,0));
    cyc(1, 0, 0, 0, 0, e(0,0,0,0), e(0,0,0,0));

    // Watchdog on M2 split; second split_req while parked is ignored
    cyc(1, 0, 1, 0, 0, e(2,0,0,0), e(2,0,0,0));
    cyc(1, 1, 1, 1, 0, e(1,0,1,0), e(1,0,1,0));
    cyc(1, 1, 1, 1, 0, e(1,0,1,0), e(1,0,1,0));
    for (int i = 0; i < 6; i++) cyc(1, 1, 1, 0, 0, e(1,0,1,0), e(1,0,1,0));
    cyc(1, 1, 1, 0, 0, e(1,0,0,1), e(1,0,0,1));
    cyc(1, 1, 1, 0, 0, e(1,0,0,0), e(1,0,0,0));
    cyc(1, 0, 1, 0, 0, e(2,0,0,0), e(2,0,0,0));
    cyc(1, 0, 0, 0, 0, e(0,0,0,0), e(0,0,0,0));

    // Reset during an M2 burst with M1 parked
    cyc(1, 1, 0, 0, 0, e(1,0,0,0), e(1,0,0,0));
    cyc(1, 1, 1, 1, 0, e(2,1,0,0), e(2,1,0,0));
    cyc(1, 1, 1, 0, 0, e(2,1,0,0), e(2,1,0,0));
    cyc(0, 1, 1, 0, 0, e(0,0,0,0), e(0,0,0,0));
    cyc(1, 1, 1, 0, 0, e(1,0,0,0), e(1,0,0,0));
    cyc(1, 0, 0, 0, 0, e(0,0,0,0), e(0,0,0,0));

    // Ignored split_req in IDLE and stray split_resume
    cyc(1, 0, 0, 1, 0, e(0,0,0,0), e(0,0,0,0));
    cyc(1, 0, 0, 0, 1, e(0,0,0,0), e(0,0,0,0));
    cyc(1, 0, 0, 0, 0, e(0,0,0,0), e(0,0,0,0));

    // split_req with simultaneous request drop; resume priority cleared by low request
    cyc(1, 1, 0, 0, 0, e(1,0,0,0), e(1,0,0,0));
    cyc(1, 0, 0, 1, 0, e(0,1,0,0), e(0,1,0,0));
    cyc(1, 0, 0, 0, 1, e(0,0,0,0), e(0,0,0,0));
    cyc(1, 0, 0, 0, 0, e(0,0,0,0), e(0,0,0,0));
    cyc(1, 1, 1, 0, 0, e(1,0,0,0), e(2,0,0,0));
    cyc(1, 0, 0, 0, 0, e(0,0,0,0), e(0,0,0,0));

    // Resume and split in the same cycle
    cyc(1, 1, 0, 0, 0, e(1,0,0,0), e(1,0,0,0));
    cyc(1, 1, 1, 1, 0, e(2,1,0,0), e(2,1,0,0));
    cyc(1, 1, 1, 1, 1, e(0,0,1,0), e(0,0,1,0));
    cyc(1, 1, 1, 0, 0, e(1,0,1,0), e(1,0,1,0));
    cyc(1, 0, 1, 0, 0, e(0,0,1,0), e(0,0,1,0));
    cyc(1, 0, 1, 0, 1, e(0,0,0,0), e(0,0,0,0));
    cyc(1, 0, 1, 0, 0, e(2,0,0,0), e(2,0,0,0));
    cyc(1, 0, 0, 0, 0, e(0,0,0,0), e(0,0,0,0));

    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drain", 32'(q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
